// File: rtl/lcd_rx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lcd_rx_pkg : shared state enum, coordinate width and pixel type     rev 1.0
// ----------------------------------------------------------------------------
package lcd_rx_pkg;

  localparam int COORD_W = 11;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    LOCK = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic coord_t sat_inc(input coord_t v, input coord_t max_v);
    return (v >= max_v) ? max_v : coord_t'(v + 1'b1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_rx_meas.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lcd_rx_meas : pixel coordinates, line/frame geometry and format compare
// Compare logic built only with LCD_RX_FMT_CHK_EN defined.           rev 1.0
// ----------------------------------------------------------------------------
module lcd_rx_meas
  import lcd_rx_pkg::*;
#(
  parameter int MAX_COORD = 2047
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de,
  input  logic               de_fall,
  input  logic               vs_start,
  input  logic               latch_en,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic [COORD_W-1:0] h_disp,
  output logic [COORD_W-1:0] v_disp,
  output logic               close_ok
);

  localparam logic [COORD_W-1:0] MAXC = COORD_W'(MAX_COORD);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, ref_w_q, ref_w_d;
  logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
  logic               first_q, first_d;
  logic [COORD_W-1:0] line_len, w_now, y_now;

  // A de_fall coincident with vs_start still belongs to the closing frame.
  always_comb begin
    line_len = sat_inc(x_q, MAXC);
    y_now    = de_fall ? sat_inc(y_q, MAXC) : y_q;
    w_now    = (de_fall && first_q) ? line_len : ref_w_q;
    x_d      = (vs_start || de_fall) ? '0 : (de ? sat_inc(x_q, MAXC) : x_q);
    if (vs_start) begin
      y_d     = '0;
      ref_w_d = '0;
      first_d = 1'b1;
    end else begin
      y_d     = y_now;
      ref_w_d = w_now;
      first_d = first_q && !de_fall;
    end
    h_d = h_q;
    v_d = v_q;
    if (vs_start && latch_en) begin
      h_d = w_now;
      v_d = y_now;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      ref_w_q <= '0;
      first_q <= 1'b1;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      ref_w_q <= ref_w_d;
      first_q <= first_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

`ifdef LCD_RX_FMT_CHK_EN
  logic mis_q, mis_d, ok_q, ok_d, mis_now, clean;

  // ok_q: the previous measured frame was clean, so it is a valid reference.
  always_comb begin
    mis_now  = mis_q || (de_fall && !first_q && (line_len != ref_w_q));
    clean    = !mis_now && (y_now != '0);
    mis_d    = vs_start ? 1'b0 : mis_now;
    ok_d     = (vs_start && latch_en) ? clean : ok_q;
    close_ok = clean && ok_q && (w_now == h_q) && (y_now == v_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
      ok_q  <= 1'b0;
    end else begin
      mis_q <= mis_d;
      ok_q  <= ok_d;
    end
  end
`else
  assign close_ok = 1'b1;
`endif

  assign cur_x  = x_q;
  assign cur_y  = y_q;
  assign h_disp = h_q;
  assign v_disp = v_q;

endmodule
`default_nettype wire

// File: rtl/lcd_rgb_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lcd_rgb_rx : DE-mode RGB565 receiver with geometry lock and format check
// Optional compare/relock feature: LCD_RX_FMT_CHK_EN.                 rev 1.0
// ----------------------------------------------------------------------------
module lcd_rgb_rx
  import lcd_rx_pkg::*;
#(
  parameter logic VS_ACT    = 1'b0,
  parameter int   MAX_COORD = 2047
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               vid_vs,
  input  logic               vid_hs,
  input  logic               vid_de,
  input  logic [15:0]        vid_rgb,
  output logic [15:0]        pix_data,
  output logic               pix_valid,
  output logic               pix_sof,
  output logic               pix_eol,
  output logic [COORD_W-1:0] pixel_xpos,
  output logic [COORD_W-1:0] pixel_ypos,
  output logic [COORD_W-1:0] h_disp,
  output logic [COORD_W-1:0] v_disp,
  output logic               frame_locked,
  output logic               fmt_err
);

  logic    s1_vs_q, s2_vs_q, s1_de_q, s2_de_q;
  rgb565_t s1_rgb_q, s2_rgb_q;
  logic    vs_start, de_fall, emit, close_ok;

  rgb565_t            data_q, data_d;
  logic               valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
  logic               sof_pend_q, sof_pend_d;
  logic [COORD_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d, cur_x, cur_y;

  rx_state_e state_q;
  logic      locked_q, err_q;

  // HS carries no timing in DE mode.
  logic unused_hs;
  assign unused_hs = vid_hs;

  assign vs_start = (s1_vs_q == VS_ACT) && (s2_vs_q != VS_ACT);
  assign de_fall  = s2_de_q && !s1_de_q;
  assign emit     = (state_q != IDLE) && s2_de_q;

  lcd_rx_meas #(.MAX_COORD(MAX_COORD)) u_meas (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .de       (s2_de_q),
    .de_fall  (de_fall),
    .vs_start (vs_start),
    .latch_en (state_q != IDLE),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .h_disp   (h_disp),
    .v_disp   (v_disp),
    .close_ok (close_ok)
  );

  // Output stage works on the s2 pixel so s1 already shows whether DE ends.
  always_comb begin
    valid_d    = emit;
    sof_d      = emit && sof_pend_q;
    eol_d      = emit && de_fall;
    data_d     = emit ? s2_rgb_q : data_q;
    xpos_d     = emit ? cur_x : xpos_q;
    ypos_d     = emit ? cur_y : ypos_q;
    sof_pend_d = vs_start ? 1'b1 : (s2_de_q ? 1'b0 : sof_pend_q);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      s1_vs_q    <= VS_ACT;
      s2_vs_q    <= VS_ACT;
      s1_de_q    <= 1'b0;
      s2_de_q    <= 1'b0;
      s1_rgb_q   <= '0;
      s2_rgb_q   <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      xpos_q     <= '0;
      ypos_q     <= '0;
      sof_pend_q <= 1'b0;
    end else begin
      s1_vs_q    <= vid_vs;
      s2_vs_q    <= s1_vs_q;
      s1_de_q    <= vid_de;
      s2_de_q    <= s1_de_q;
      s1_rgb_q   <= rgb565_t'(vid_rgb);
      s2_rgb_q   <= s1_rgb_q;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      sof_pend_q <= sof_pend_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (vs_start) state_q <= MEAS;
        MEAS: if (vs_start && close_ok) begin
          state_q  <= LOCK;
          locked_q <= 1'b1;
        end
        LOCK: if (vs_start && !close_ok) begin
          state_q  <= MEAS;
          locked_q <= 1'b0;
          err_q    <= 1'b1;
        end
        default: begin
          state_q  <= IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign pix_data     = data_q;
  assign pix_valid    = valid_q;
  assign pix_sof      = sof_q;
  assign pix_eol      = eol_q;
  assign pixel_xpos   = xpos_q;
  assign pixel_ypos   = ypos_q;
  assign frame_locked = locked_q;
  assign fmt_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_rgb_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lcd_rgb_rx : directed frame sequence with a pixel scoreboard     rev 1.0
// ----------------------------------------------------------------------------
module tb_lcd_rgb_rx;

`ifdef LCD_RX_FMT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        vid_vs    = 1'b1;
  logic        vid_hs    = 1'b1;
  logic        vid_de    = 1'b0;
  logic [15:0] vid_rgb   = '0;
  logic [15:0] pix_data;
  logic        pix_valid, pix_sof, pix_eol, frame_locked, fmt_err;
  logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;

  lcd_rgb_rx dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .vid_vs       (vid_vs),
    .vid_hs       (vid_hs),
    .vid_de       (vid_de),
    .vid_rgb      (vid_rgb),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_sof      (pix_sof),
    .pix_eol      (pix_eol),
    .pixel_xpos   (pixel_xpos),
    .pixel_ypos   (pixel_ypos),
    .h_disp       (h_disp),
    .v_disp       (v_disp),
    .frame_locked (frame_locked),
    .fmt_err      (fmt_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [15:0] d;
    logic [10:0] x;
    logic [10:0] y;
    logic        sof;
    logic        eol;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0, fails = 0;
  int          err_cnt = 0, exp_err = 0;
  int          valid_cnt = 0, exp_valid = 0, sof_cnt = 0, exp_sof = 0;
  logic [10:0] sof_x = '1, sof_y = '1;
  bit          rx_active = 1'b0, first_pix = 1'b0;
  int          line_y = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] sat(input int v);
    return (v > 2047) ? 11'd2047 : 11'(v);
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Opens a frame (and closes the previous one).
  task automatic drive_vs();
    vid_de    = 1'b0;
    vid_vs    = 1'b0;
    rx_active = 1'b1;
    first_pix = 1'b1;
    line_y    = 0;
    repeat (3) tick();
    vid_vs = 1'b1;
    repeat (2) tick();
  endtask

  task automatic drive_lines(input int w, input int h, input int bad_line, input int bad_w);
    for (int l = 0; l < h; l++) begin
      int ww;
      ww = (l == bad_line) ? bad_w : w;
      for (int c = 0; c < ww; c++) begin
        vid_de  = 1'b1;
        vid_rgb = 16'($urandom);
        if (rx_active) begin
          sb.push_back('{d: vid_rgb, x: sat(c), y: sat(line_y), sof: first_pix, eol: (c == ww - 1)});
          exp_valid++;
          if (first_pix) exp_sof++;
        end
        first_pix = 1'b0;
        tick();
      end
      vid_de = 1'b0;
      vid_hs = 1'b0;
      repeat (2) tick();
      vid_hs = 1'b1;
      repeat (2) tick();
      line_y++;
    end
  endtask

  task automatic chk_close(input string tag, input int h, input int v, input bit lk);
    chk({tag, "_h_disp"}, 64'(h_disp), 64'(h));
    chk({tag, "_v_disp"}, 64'(v_disp), 64'(v));
    chk({tag, "_locked"}, 64'(frame_locked), 64'(lk));
    chk({tag, "_fmt_err_count"}, 64'(err_cnt), 64'(exp_err));
    chk({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: pops the scoreboard for every emitted pixel.
  always @(negedge sys_clk) begin
    exp_t e;
    if (fmt_err) err_cnt++;
    if (pix_valid) begin
      valid_cnt++;
      if (pix_sof) begin
        sof_cnt++;
        sof_x = pixel_xpos;
        sof_y = pixel_ypos;
      end
      chk("pixel_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pixel", 64'({pix_data, pixel_xpos, pixel_ypos, pix_sof, pix_eol}), 64'(e));
      end
    end
  end

  initial begin
    repeat (3) tick();
    chk("reset_pix", 64'({pix_data, pix_valid, pix_sof, pix_eol, pixel_xpos, pixel_ypos}), 64'd0);
    chk("reset_geom", 64'({h_disp, v_disp, frame_locked, fmt_err}), 64'd0);
    sys_rst_n = 1'b1;
    repeat (2) tick();

    // Three clean frames, then a short line, then relock.
    drive_vs(); drive_lines(40, 12, -1, 0);
    drive_vs(); chk_close("f1", 40, 12, !CHK); drive_lines(40, 12, -1, 0);
    drive_vs(); chk_close("f2", 40, 12, 1'b1); drive_lines(40, 12, -1, 0);
    drive_vs(); chk_close("f3", 40, 12, 1'b1); drive_lines(40, 12, 5, 39);
    exp_err += int'(CHK);
    drive_vs(); chk_close("short_line", 40, 12, !CHK); drive_lines(40, 12, -1, 0);
    drive_vs(); chk_close("relock_a", 40, 12, !CHK); drive_lines(40, 12, -1, 0);
    drive_vs(); chk_close("relock_b", 40, 12, 1'b1); drive_lines(24, 7, -1, 0);

    // Geometry change.
    exp_err += int'(CHK);
    drive_vs(); chk_close("resize_1", 24, 7, !CHK); drive_lines(24, 7, -1, 0);
    drive_vs(); chk_close("resize_2", 24, 7, 1'b1); drive_lines(1, 3, -1, 0);

    // Single-pixel lines, then lines long enough to saturate x and width.
    exp_err += int'(CHK);
    drive_vs(); chk_close("single_px", 1, 3, !CHK); drive_lines(2050, 2, -1, 0);
    drive_vs(); chk_close("long_line", 2047, 2, !CHK); drive_lines(24, 2, -1, 0);

    // Reset asserted on the first pixel of a line, released mid-line.
    rx_active = 1'b0;
    vid_de    = 1'b1;
    sys_rst_n = 1'b0;
    repeat (2) tick();
    chk("mid_reset_outputs", 64'({pix_valid, frame_locked, h_disp, v_disp}), 64'd0);
    tick();
    sys_rst_n = 1'b1;
    repeat (10) tick();
    vid_de = 1'b0;
    repeat (4) tick();
    drive_lines(24, 2, -1, 0);
    chk("post_reset_h_disp", 64'(h_disp), 64'd0);
    chk("post_reset_sb", 64'(sb.size()), 64'd0);
    drive_vs(); drive_lines(24, 7, -1, 0);
    chk("post_reset_sof_pos", 64'({sof_x, sof_y}), 64'd0);
    drive_vs(); chk_close("post_reset", 24, 7, !CHK);

    repeat (6) tick();
    chk("valid_total", 64'(valid_cnt), 64'(exp_valid));
    chk("sof_total", 64'(sof_cnt), 64'(exp_sof));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
